// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_dbg_pkg
// Purpose  : Shared encodings for the CPU run/debug controller: FSM state
//            encoding, run-mode codes and halt-cause codes.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_IDLE       = 3'd1,
        S_RUN        = 3'd2,
        S_STEP       = 3'd3,
        S_HALT       = 3'd4
    } state_t;

    localparam logic [1:0] c_MODE_FREE  = 2'b00;
    localparam logic [1:0] c_MODE_STEP  = 2'b01;
    localparam logic [1:0] c_MODE_RUNN  = 2'b10;
    localparam logic [1:0] c_MODE_HOLD  = 2'b11;

    localparam logic [1:0] c_CAUSE_NONE   = 2'd0;
    localparam logic [1:0] c_CAUSE_STEP   = 2'd1;
    localparam logic [1:0] c_CAUSE_BP     = 2'd2;
    localparam logic [1:0] c_CAUSE_BUDGET = 2'd3;

endpackage : cpu_dbg_pkg
`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl_if
// Purpose  : Debug-host / core-tap bundle of the run controller.
//            master : host side (drives MODE/GO/budget/breakpoint, core taps
//                     PC/ALU_OUTPUT, trace read index; observes status).
//            slave  : controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_run_ctrl_if #(
    parameter int PC_W     = 8,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 20,
    parameter int TR_DEPTH = 16
);
    localparam int TR_AW = $clog2(TR_DEPTH);

    logic [1:0]        MODE;
    logic              GO;
    logic [CNT_W-1:0]  N_CYCLES;
    logic              BP_EN;
    logic [PC_W-1:0]   BP_ADDR;
    logic [PC_W-1:0]   PC;
    logic [DATA_W-1:0] ALU_OUTPUT;
    logic              CPU_RST;
    logic              CPU_EN;
    logic              HALTED;
    logic [1:0]        HALT_CAUSE;
    logic [CNT_W-1:0]  CYCLE_CNT;
    logic [TR_AW-1:0]  TR_RD_IDX;
    logic [PC_W-1:0]   TR_PC;
    logic [DATA_W-1:0] TR_DATA;
    logic [TR_AW:0]    TR_COUNT;

    modport master (
        output MODE, GO, N_CYCLES, BP_EN, BP_ADDR, PC, ALU_OUTPUT, TR_RD_IDX,
        input  CPU_RST, CPU_EN, HALTED, HALT_CAUSE, CYCLE_CNT, TR_PC, TR_DATA, TR_COUNT
    );

    modport slave (
        input  MODE, GO, N_CYCLES, BP_EN, BP_ADDR, PC, ALU_OUTPUT, TR_RD_IDX,
        output CPU_RST, CPU_EN, HALTED, HALT_CAUSE, CYCLE_CNT, TR_PC, TR_DATA, TR_COUNT
    );

endinterface : cpu_run_ctrl_if
`default_nettype wire

// File: rtl/cpu_run_ctrl_trace_ring.sv
`default_nettype none
// ============================================================================
// Module   : trace_ring
// Purpose  : Circular trace buffer. Each i_wr_en cycle stores i_wr_data,
//            overwriting the oldest entry once full. Read is combinational
//            and indexed relative to the newest entry (0 = most recent);
//            indices at or beyond the valid count read as zero.
// Ports    : i_clk, i_rst (sync, active-high), i_wr_en, i_wr_data,
//            i_rd_idx, o_rd_data, o_count (valid entries, saturating)
// Revision : 1.0 - initial release
// ============================================================================
module trace_ring #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
    input  wire logic          i_wr_en,
    input  wire logic [W-1:0]  i_wr_data,
    input  wire logic [AW-1:0] i_rd_idx,
    output logic      [W-1:0]  o_rd_data,
    output logic      [AW:0]   o_count
);
    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_rd_addr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_count != c_FULL) begin
                r_count <= r_count + (AW+1)'(1);
            end
        end
    end

    // Contents need no reset: reads beyond r_count are masked to zero.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Newest entry sits one below the write pointer; modulo arithmetic wraps.
    assign w_rd_addr = r_wr_ptr - AW'(1) - i_rd_idx;
    assign o_rd_data = ({1'b0, i_rd_idx} < r_count) ? r_mem[w_rd_addr] : '0;
    assign o_count   = r_count;

endmodule : trace_ring
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Run/debug controller for the microprocessor core. Holds core
//            reset for RST_CYCLES after board reset, then runs the core in
//            free-run, single-step or run-N mode with an optional PC
//            breakpoint, counting enabled cycles and tracing {PC, ALU_OUTPUT}.
// Ports    : CLK, RST (sync, active-high); bus (slave modport) carries
//            MODE/GO/N_CYCLES/BP_EN/BP_ADDR, core taps PC/ALU_OUTPUT,
//            core controls CPU_RST/CPU_EN, status HALTED/HALT_CAUSE/CYCLE_CNT
//            and trace read port TR_RD_IDX/TR_PC/TR_DATA/TR_COUNT.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int DATA_W     = 8,
    parameter int RST_CYCLES = 5,
    parameter int CNT_W      = 20,
    parameter int TR_DEPTH   = 16
) (
    input wire logic       CLK,
    input wire logic       RST,
    cpu_run_ctrl_if.slave  bus
);
    localparam int TR_AW  = $clog2(TR_DEPTH);
    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [CNT_W-1:0]   r_budget;
    logic               r_bounded;
    logic               r_first;
    logic [1:0]         r_cause;
    logic [1:0]         w_cause_next;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic               w_go_accept;
    logic               w_bp_hit;
    logic               w_cpu_en;
    logic [PC_W+DATA_W-1:0] w_tr_rd;

    // r_first masks the breakpoint on the first RUN cycle so a resume
    // executes the instruction that triggered the previous halt.
    assign w_bp_hit    = bus.BP_EN & (bus.PC == bus.BP_ADDR) & ~r_first;
    assign w_cpu_en    = ((r_state == S_RUN) & ~w_bp_hit) | (r_state == S_STEP);
    assign w_go_accept = bus.GO & (bus.MODE != c_MODE_HOLD) &
                         ((r_state == S_IDLE) | (r_state == S_HALT));

    always_comb begin
        w_next_state = r_state;
        w_cause_next = r_cause;
        case (r_state)
            S_RESET_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) w_next_state = S_IDLE;
            end
            S_IDLE, S_HALT: begin
                if (w_go_accept) begin
                    w_cause_next = c_CAUSE_NONE;
                    case (bus.MODE)
                        c_MODE_STEP: w_next_state = S_STEP;
                        c_MODE_RUNN: begin
                            if (bus.N_CYCLES == '0) begin
                                w_next_state = S_HALT;
                                w_cause_next = c_CAUSE_BUDGET;
                            end else begin
                                w_next_state = S_RUN;
                            end
                        end
                        default:     w_next_state = S_RUN;
                    endcase
                end
            end
            S_RUN: begin
                if (w_bp_hit) begin
                    w_next_state = S_HALT;
                    w_cause_next = c_CAUSE_BP;
                end else if (r_bounded && (r_budget == CNT_W'(1))) begin
                    w_next_state = S_HALT;
                    w_cause_next = c_CAUSE_BUDGET;
                end
            end
            S_STEP: begin
                w_next_state = S_HALT;
                w_cause_next = c_CAUSE_STEP;
            end
            default: w_next_state = S_RESET_HOLD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_RESET_HOLD;
            r_hold_cnt  <= '0;
            r_budget    <= '0;
            r_bounded   <= 1'b0;
            r_first     <= 1'b1;
            r_cause     <= c_CAUSE_NONE;
            r_cycle_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_cause <= w_cause_next;
            r_first <= (r_state != S_RUN);
            if ((r_state == S_RESET_HOLD) && (w_next_state == S_RESET_HOLD)) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end
            if (w_go_accept) begin
                r_budget  <= bus.N_CYCLES;
                r_bounded <= (bus.MODE == c_MODE_RUNN);
            end else if (w_cpu_en && r_bounded) begin
                r_budget <= r_budget - CNT_W'(1);
            end
            if (w_cpu_en && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
        end
    end

    trace_ring #(
        .W     (PC_W + DATA_W),
        .DEPTH (TR_DEPTH),
        .AW    (TR_AW)
    ) u_trace_ring (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_wr_en   (w_cpu_en),
        .i_wr_data ({bus.PC, bus.ALU_OUTPUT}),
        .i_rd_idx  (bus.TR_RD_IDX),
        .o_rd_data (w_tr_rd),
        .o_count   (bus.TR_COUNT)
    );

    assign bus.CPU_RST    = (r_state == S_RESET_HOLD);
    assign bus.CPU_EN     = w_cpu_en;
    assign bus.HALTED     = (r_state == S_HALT);
    assign bus.HALT_CAUSE = r_cause;
    assign bus.CYCLE_CNT  = r_cycle_cnt;
    assign bus.TR_PC      = w_tr_rd[PC_W+DATA_W-1:DATA_W];
    assign bus.TR_DATA    = w_tr_rd[DATA_W-1:0];

endmodule : cpu_run_ctrl
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Purpose  : Directed self-checking bench for cpu_run_ctrl. A tiny core model
//            advances its PC on every enabled cycle; ALU_OUTPUT = PC ^ 8'hA5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;
    import cpu_dbg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    cpu_run_ctrl_if #(.PC_W(8), .DATA_W(8), .CNT_W(20), .TR_DEPTH(16)) bus ();

    cpu_run_ctrl #(
        .PC_W(8), .DATA_W(8), .RST_CYCLES(5), .CNT_W(20), .TR_DEPTH(16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Core model: PC restarts at 0 under core reset, advances when enabled.
    logic [7:0] core_pc = 8'd0;
    always @(posedge clk) begin
        if (bus.CPU_RST)     core_pc <= 8'd0;
        else if (bus.CPU_EN) core_pc <= core_pc + 8'd1;
    end
    assign bus.PC         = core_pc;
    assign bus.ALU_OUTPUT = core_pc ^ 8'hA5;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go;
        bus.GO = 1'b1;
        tick();
        bus.GO = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20 && bus.CPU_RST; i++) tick();
        n_checks++;
        if (bus.CPU_RST !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_timeout: CPU_RST=%0b required 0", bus.CPU_RST);
        end
    endtask

    task automatic test_reset;
        int hi_cnt;
        int en_cnt;
        int last_hi;
        tick();
        n_checks++;
        if ({bus.CPU_RST, bus.CPU_EN, bus.HALTED, bus.HALT_CAUSE} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: rst/en/halted/cause=%b required 10000",
                     {bus.CPU_RST, bus.CPU_EN, bus.HALTED, bus.HALT_CAUSE});
        end
        n_checks++;
        if (bus.CYCLE_CNT !== 20'd0 || bus.TR_COUNT !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_counters: cycle=%0d tr_count=%0d required 0/0",
                     bus.CYCLE_CNT, bus.TR_COUNT);
        end
        rst = 1'b0;
        hi_cnt = 0; en_cnt = 0; last_hi = -1;
        for (int i = 0; i < 10; i++) begin
            if (bus.CPU_RST) begin hi_cnt++; last_hi = i; end
            if (bus.CPU_EN) en_cnt++;
            tick();
        end
        n_checks++;
        if (hi_cnt !== 5 || last_hi !== 4) begin
            n_fail++;
            $display("FAIL reset_hold_len: high=%0d last=%0d required 5/4", hi_cnt, last_hi);
        end
        n_checks++;
        if (en_cnt !== 0 || bus.HALTED !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_idle: en_cycles=%0d halted=%0b required 0/0", en_cnt, bus.HALTED);
        end
    endtask

    task automatic test_run_n;
        int en_cnt;
        int first_en;
        int last_en;
        bus.MODE = c_MODE_RUNN;
        bus.N_CYCLES = 20'd7;
        pulse_go();
        en_cnt = 0; first_en = -1; last_en = -1;
        for (int i = 0; i < 12; i++) begin
            if (bus.CPU_EN) begin
                en_cnt++;
                if (first_en < 0) first_en = i;
                last_en = i;
            end
            tick();
        end
        n_checks++;
        if (en_cnt !== 7 || first_en !== 0 || last_en !== 6) begin
            n_fail++;
            $display("FAIL run_n_pulses: count=%0d first=%0d last=%0d required 7/0/6",
                     en_cnt, first_en, last_en);
        end
        n_checks++;
        if (bus.HALTED !== 1'b1 || bus.HALT_CAUSE !== 2'd3 || bus.CYCLE_CNT !== 20'd7) begin
            n_fail++;
            $display("FAIL run_n_halt: halted=%0b cause=%0d cycle=%0d required 1/3/7",
                     bus.HALTED, bus.HALT_CAUSE, bus.CYCLE_CNT);
        end
    endtask

    task automatic test_breakpoint;
        int en_cnt;
        do_reset();
        bus.MODE = c_MODE_FREE;
        bus.BP_EN = 1'b1;
        bus.BP_ADDR = 8'h04;
        pulse_go();
        en_cnt = 0;
        for (int i = 0; i < 30 && !bus.HALTED; i++) begin
            if (bus.CPU_EN) en_cnt++;
            tick();
        end
        n_checks++;
        if (bus.HALTED !== 1'b1 || bus.HALT_CAUSE !== 2'd2 || bus.PC !== 8'h04) begin
            n_fail++;
            $display("FAIL bp_halt: halted=%0b cause=%0d pc=%0h required 1/2/4",
                     bus.HALTED, bus.HALT_CAUSE, bus.PC);
        end
        n_checks++;
        if (en_cnt !== 4 || bus.CYCLE_CNT !== 20'd4) begin
            n_fail++;
            $display("FAIL bp_cycles: en=%0d cycle=%0d required 4/4", en_cnt, bus.CYCLE_CNT);
        end
        pulse_go();
        n_checks++;
        if (bus.CPU_EN !== 1'b1 || bus.HALT_CAUSE !== 2'd0 || bus.HALTED !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_resume: en=%0b cause=%0d halted=%0b required 1/0/0",
                     bus.CPU_EN, bus.HALT_CAUSE, bus.HALTED);
        end
        tick(); tick(); tick();
        n_checks++;
        if (bus.PC !== 8'h07 || bus.HALTED !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_continue: pc=%0h halted=%0b required 7/0", bus.PC, bus.HALTED);
        end
        bus.BP_EN = 1'b0;
    endtask

    task automatic test_step;
        int bad;
        do_reset();
        bus.MODE = c_MODE_STEP;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            pulse_go();
            if (bus.CPU_EN !== 1'b1 || bus.HALT_CAUSE !== 2'd0) bad++;
            tick();
            if (bus.CPU_EN !== 1'b0 || bus.HALTED !== 1'b1 || bus.HALT_CAUSE !== 2'd1) bad++;
            tick();
            if (bus.CPU_EN !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL step_pulses: bad_observations=%0d required 0", bad);
        end
        bus.TR_RD_IDX = 4'd0;
        #1;
        n_checks++;
        if (bus.TR_COUNT !== 5'd3 || bus.TR_PC !== 8'h02 || bus.TR_DATA !== 8'hA7) begin
            n_fail++;
            $display("FAIL step_trace_newest: count=%0d pc=%0h data=%0h required 3/2/a7",
                     bus.TR_COUNT, bus.TR_PC, bus.TR_DATA);
        end
        bus.TR_RD_IDX = 4'd2;
        #1;
        n_checks++;
        if (bus.TR_PC !== 8'h00 || bus.TR_DATA !== 8'hA5) begin
            n_fail++;
            $display("FAIL step_trace_oldest: pc=%0h data=%0h required 0/a5", bus.TR_PC, bus.TR_DATA);
        end
        bus.TR_RD_IDX = 4'd3;
        #1;
        n_checks++;
        if (bus.TR_PC !== 8'h00 || bus.TR_DATA !== 8'h00) begin
            n_fail++;
            $display("FAIL step_trace_beyond: pc=%0h data=%0h required 0/0", bus.TR_PC, bus.TR_DATA);
        end
        bus.TR_RD_IDX = 4'd0;
    endtask

    task automatic test_budget_zero_and_hold;
        bus.MODE = c_MODE_RUNN;
        bus.N_CYCLES = 20'd0;
        pulse_go();
        n_checks++;
        if (bus.HALTED !== 1'b1 || bus.HALT_CAUSE !== 2'd3 || bus.CPU_EN !== 1'b0 ||
            bus.CYCLE_CNT !== 20'd3) begin
            n_fail++;
            $display("FAIL budget_zero: halted=%0b cause=%0d en=%0b cycle=%0d required 1/3/0/3",
                     bus.HALTED, bus.HALT_CAUSE, bus.CPU_EN, bus.CYCLE_CNT);
        end
        bus.MODE = c_MODE_HOLD;
        pulse_go();
        tick();
        n_checks++;
        if (bus.HALTED !== 1'b1 || bus.HALT_CAUSE !== 2'd3 || bus.CYCLE_CNT !== 20'd3) begin
            n_fail++;
            $display("FAIL mode_hold_go: halted=%0b cause=%0d cycle=%0d required 1/3/3",
                     bus.HALTED, bus.HALT_CAUSE, bus.CYCLE_CNT);
        end
    endtask

    task automatic test_trace_wrap;
        do_reset();
        bus.MODE = c_MODE_RUNN;
        bus.N_CYCLES = 20'd20;
        pulse_go();
        for (int i = 0; i < 40 && !bus.HALTED; i++) tick();
        bus.TR_RD_IDX = 4'd15;
        #1;
        n_checks++;
        if (bus.TR_COUNT !== 5'd16 || bus.CYCLE_CNT !== 20'd20 || bus.HALT_CAUSE !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_count: tr_count=%0d cycle=%0d cause=%0d required 16/20/3",
                     bus.TR_COUNT, bus.CYCLE_CNT, bus.HALT_CAUSE);
        end
        n_checks++;
        if (bus.TR_PC !== 8'h04 || bus.TR_DATA !== 8'hA1) begin
            n_fail++;
            $display("FAIL wrap_oldest: pc=%0h data=%0h required 4/a1", bus.TR_PC, bus.TR_DATA);
        end
        bus.TR_RD_IDX = 4'd0;
        #1;
        n_checks++;
        if (bus.TR_PC !== 8'h13 || bus.TR_DATA !== 8'hB6) begin
            n_fail++;
            $display("FAIL wrap_newest: pc=%0h data=%0h required 13/b6", bus.TR_PC, bus.TR_DATA);
        end
    endtask

    task automatic test_reset_mid_run;
        bus.MODE = c_MODE_FREE;
        pulse_go();
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (bus.CPU_EN !== 1'b1 || bus.CYCLE_CNT !== 20'd25) begin
            n_fail++;
            $display("FAIL mid_run_active: en=%0b cycle=%0d required 1/25", bus.CPU_EN, bus.CYCLE_CNT);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.CPU_RST !== 1'b1 || bus.CPU_EN !== 1'b0 || bus.CYCLE_CNT !== 20'd0 ||
            bus.TR_COUNT !== 5'd0 || bus.HALT_CAUSE !== 2'd0 || bus.HALTED !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset: rst=%0b en=%0b cycle=%0d tr=%0d cause=%0d halted=%0b required 1/0/0/0/0/0",
                     bus.CPU_RST, bus.CPU_EN, bus.CYCLE_CNT, bus.TR_COUNT, bus.HALT_CAUSE, bus.HALTED);
        end
    endtask

    initial begin
        bus.MODE      = 2'b00;
        bus.GO        = 1'b0;
        bus.N_CYCLES  = '0;
        bus.BP_EN     = 1'b0;
        bus.BP_ADDR   = '0;
        bus.TR_RD_IDX = '0;
        test_reset();
        test_run_n();
        test_breakpoint();
        test_step();
        test_budget_zero_and_hold();
        test_trace_wrap();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cpu_run_ctrl
`default_nettype wire
